// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures {PC, WriteData} each time the datapath PC advances,
// buffers the pairs in a show-ahead FIFO drained via a valid/ready port, and
// flags end-of-program when the PC stays put (final jump-to-self).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   pc_in, wd_in      ProgramCounter / WB WriteData from the datapath
//   cap_en            enables pushes (halt detection runs regardless)
//   clr_ovf           synchronous clear of the sticky overflow flag
//   out_ready         consumer accepts the head entry
//   out_valid         FIFO non-empty
//   out_pc, out_wd    head entry (zero when empty)
//   count             occupancy 0..DEPTH
//   overflow          sticky: a push was dropped because the FIFO was full
//   halted            PC unchanged for at least HALT_CYCLES cycles
module wb_trace_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              wd_in,
    input  logic                     cap_en,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_wd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = 8;

    logic [31:0]   mem_pc [DEPTH];
    logic [31:0]   mem_wd [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   prev_pc;
    logic          first;
    logic [HW-1:0] halt_cnt;

    logic          adv;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;
    logic          same;
    logic [CW-1:0] count_nxt;
    logic [HW-1:0] halt_cnt_nxt;

    // Control decode: change detect, push/pop qualification, next occupancy and halt count
    always_comb begin
        adv          = first | (pc_in != prev_pc);
        push         = cap_en & adv;
        pop          = out_valid & out_ready;
        full         = (count == CW'(DEPTH));
        // When full, a push can only land if the head leaves on the same edge
        wr_en        = push & (~full | pop);
        drop         = push & full & ~pop;
        same         = ~first & (pc_in == prev_pc);
        count_nxt    = count;
        halt_cnt_nxt = '0;
        if (wr_en && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !wr_en) begin
            count_nxt = count - CW'(1);
        end
        if (same) begin
            halt_cnt_nxt = (halt_cnt == HW'(HALT_CYCLES)) ? halt_cnt : halt_cnt + HW'(1);
        end
    end

    // Entry storage; contents are don't-care until written, outputs are masked when empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr] <= pc_in;
            mem_wd[wr_ptr] <= wd_in;
        end
    end

    // Pointers, occupancy, flags and change/halt tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            prev_pc   <= '0;
            first     <= 1'b1;
            halt_cnt  <= '0;
            halted    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
            prev_pc  <= pc_in;
            first    <= 1'b0;
            halt_cnt <= halt_cnt_nxt;
            halted   <= (halt_cnt_nxt == HW'(HALT_CYCLES));
        end
    end

    // Show-ahead head view
    assign out_pc = out_valid ? mem_pc[rd_ptr] : '0;
    assign out_wd = out_valid ? mem_wd[rd_ptr] : '0;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;
    localparam int HALT  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] wd_in;
    logic        cap_en;
    logic        clr_ovf;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_wd;
    logic [4:0]  count;
    logic        overflow;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] q[$];
    bit          m_first;
    bit          m_ovf;
    int          m_same;
    logic [31:0] m_prev;

    wb_trace_fifo #(.DEPTH(DEPTH), .HALT_CYCLES(HALT)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_in     (pc_in),
        .wd_in     (wd_in),
        .cap_en    (cap_en),
        .clr_ovf   (clr_ovf),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_wd    (out_wd),
        .count     (count),
        .overflow  (overflow),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_pc();
        return (q.size() != 0) ? q[0][63:32] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_wd();
        return (q.size() != 0) ? q[0][31:0] : 32'h0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_first = 1'b1;
        m_ovf   = 1'b0;
        m_same  = 0;
        m_prev  = 32'h0;
    endtask

    // One clock: model consumes the inputs present at the edge, then settle #1
    task automatic cycle();
        logic [31:0] p   = pc_in;
        logic [31:0] w   = wd_in;
        bit          ce  = cap_en;
        bit          rdy = out_ready;
        bit          clr = clr_ovf;
        bit          changed = m_first || (p != m_prev);
        bit          psh = ce && changed;
        bit          pp  = (q.size() != 0) && rdy;
        bit          was_full = (q.size() == DEPTH);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (psh && was_full && !pp) m_ovf = 1'b1;
        else begin
            if (psh) q.push_back({p, w});
            if (clr) m_ovf = 1'b0;
        end
        if (!m_first && p == m_prev) m_same = (m_same < 1000) ? m_same + 1 : m_same;
        else m_same = 0;
        m_first = 1'b0;
        m_prev  = p;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pc_in = 32'h0; wd_in = 32'h0;
        cap_en = 1'b1; clr_ovf = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_fifo: count=%0d valid=%b pc=%h wd=%h, required 0/0/0/0", count, out_valid, out_pc, out_wd);
        end
        checks++;
        if (overflow !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: overflow=%b halted=%b, required 0/0", overflow, halted);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        cap_en = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'(4 * i);
            wd_in = 32'(8'h11 * (i + 1));
            cycle();
        end
        checks++;
        if (count !== 5'd4 || out_valid !== 1'b1 || out_pc !== 32'h0 || out_wd !== 32'h11) begin
            errors++;
            $display("FAIL basic_fill: count=%0d valid=%b head=%h/%h, required 4/1/0/11", count, out_valid, out_pc, out_wd);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_pc !== 32'(4 * i) || out_wd !== 32'(8'h11 * (i + 1))) begin
                errors++;
                $display("FAIL basic_drain%0d: head=%h/%h, required %h/%h", i, out_pc, out_wd, 4 * i, 8'h11 * (i + 1));
            end
            cycle();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL basic_empty: count=%0d valid=%b pc=%h, required 0/0/0", count, out_valid, out_pc);
        end
    endtask

    task automatic test_stall();
        cap_en = 1'b1; out_ready = 1'b0;
        pc_in = 32'h20;
        wd_in = 32'hA1; cycle();
        wd_in = 32'hA2; cycle();
        wd_in = 32'hA3; cycle();
        checks++;
        if (count !== 5'd1 || out_pc !== 32'h20 || out_wd !== 32'hA1) begin
            errors++;
            $display("FAIL stall_one_entry: count=%0d head=%h/%h, required 1/20/a1", count, out_pc, out_wd);
        end
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: count=%0d valid=%b, required 0/0", count, out_valid);
        end
    endtask

    task automatic test_overflow();
        cap_en = 1'b1; out_ready = 1'b0; clr_ovf = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            pc_in = 32'h1000 + 32'(4 * i);
            wd_in = 32'h100 + 32'(i);
            cycle();
        end
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: count=%0d overflow=%b, required 16/0", count, overflow);
        end
        pc_in = 32'h1040; wd_in = 32'h999; cycle();
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1 || out_pc !== 32'h1000) begin
            errors++;
            $display("FAIL ovf_drop: count=%0d overflow=%b head=%h, required 16/1/1000", count, overflow, out_pc);
        end
        pc_in = 32'h1044; clr_ovf = 1'b1; cycle();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: overflow=%b, required 1", overflow);
        end
        cycle();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%b count=%0d, required 0/16", overflow, count);
        end
    endtask

    task automatic test_full_pop();
        pc_in = 32'h1050; wd_in = 32'h555; out_ready = 1'b1; cycle();
        out_ready = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || out_pc !== 32'h1004 || out_wd !== 32'h101) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d overflow=%b head=%h/%h, required 16/0/1004/101", count, overflow, out_pc, out_wd);
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_pc !== exp_pc() || out_wd !== exp_wd()) begin
                errors++;
                $display("FAIL full_drain%0d: head=%h/%h, required %h/%h", i, out_pc, out_wd, exp_pc(), exp_wd());
            end
            if (i == DEPTH - 1) begin
                checks++;
                if (out_pc !== 32'h1050) begin
                    errors++;
                    $display("FAIL full_tail: pc=%h, required 1050", out_pc);
                end
            end
            cycle();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL full_empty: count=%0d, required 0", count);
        end
    endtask

    task automatic test_halt();
        cap_en = 1'b0;
        pc_in = 32'h5C; cycle();
        for (int k = 1; k <= HALT; k++) begin
            cycle();
            checks++;
            if (halted !== (k >= HALT)) begin
                errors++;
                $display("FAIL halt_after%0d: halted=%b, required %b", k, halted, k >= HALT);
            end
        end
        cycle();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold: halted=%b, required 1", halted);
        end
        pc_in = 32'h60; cycle();
        checks++;
        if (halted !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL halt_release: halted=%b count=%0d, required 0/0", halted, count);
        end
        cap_en = 1'b1;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (hold > 0) hold--;
            else if ($urandom_range(0, 19) == 0) hold = $urandom_range(5, 12);
            else if ($urandom_range(0, 3) != 0) pc_in = 32'($urandom_range(0, 63)) << 2;
            wd_in     = $urandom;
            cap_en    = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            clr_ovf   = ($urandom_range(0, 9) == 0);
            cycle();
            checks++;
            if (count !== 5'(q.size()) || out_valid !== (q.size() != 0) || out_pc !== exp_pc() || out_wd !== exp_wd()
                || overflow !== m_ovf || halted !== (m_same >= HALT)) begin
                errors++;
                $display("FAIL random%0d: count=%0d valid=%b head=%h/%h ovf=%b halt=%b, required %0d/%b/%h/%h/%b/%b",
                         n, count, out_valid, out_pc, out_wd, overflow, halted,
                         q.size(), q.size() != 0, exp_pc(), exp_wd(), m_ovf, m_same >= HALT);
            end
        end
        clr_ovf = 1'b0; out_ready = 1'b0; cap_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; cap_en = 1'b0;
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL mid_predrain: count=%0d, required 0 within 40 cycles", count);
        end
        out_ready = 1'b0; cap_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pc_in = 32'h200 + 32'(4 * i);
            wd_in = 32'h700 + 32'(i);
            cycle();
        end
        out_ready = 1'b1; cycle();
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL mid_count5: count=%0d, required 5", count);
        end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_wd !== 32'h0 || overflow !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL mid_async_reset: count=%0d valid=%b head=%h/%h ovf=%b halt=%b, required all 0",
                     count, out_valid, out_pc, out_wd, overflow, halted);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();
        checks++;
        if (count !== 5'd1 || out_pc !== 32'h214 || out_wd !== 32'h705) begin
            errors++;
            $display("FAIL mid_first_push: count=%0d head=%h/%h, required 1/214/705", count, out_pc, out_wd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_full_pop();
        test_halt();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
